pong_referee: RTL and testbench

Rally referee for the pong datapath. Consumes the ball mover's position and direction, detects when the ball passes a paddle into a goal zone, keeps both players' scores, and sequences the serve: it gates ball motion (`ball_enable`) and issues a one-cycle `serve` pulse with the initial direction. It sits between the ball mover and the score display/renderer, on the same `clk` domain.

---
 rtl/pong_pkg.sv | 18 +
 rtl/score_counter.sv | 22 ++
 rtl/pong_referee.sv | 143 ++++++++++++++
 tb/tb_pong_referee.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong rally referee.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    PLAY = 2'b10,
    OVER = 2'b11
  } state_t;

  localparam logic [1:0] UP_LEFT    = 2'b00;
  localparam logic [1:0] DOWN_LEFT  = 2'b01;
  localparam logic [1:0] UP_RIGHT   = 2'b10;
  localparam logic [1:0] DOWN_RIGHT = 2'b11;

  localparam int SCORE_W = 4;

endpackage

// File: rtl/score_counter.sv
// Per-player score register: saturating up-counter with synchronous clear.
module score_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pong_referee.sv
// Rally referee: miss detection, scoring and serve sequencing for pong.
// Optional win limit (OVER state, game_over) enabled by PONG_WIN_LIMIT_EN.
module pong_referee
  import pong_pkg::*;
#(
  parameter int DISP_COLS   = 800,
  parameter int B_WIDTH     = 6,
  parameter int L_GOAL_COL  = 4,
  parameter int R_GOAL_COL  = DISP_COLS - 4,
  parameter int SERVE_DELAY = 6_000_000,
  parameter int WIN_SCORE   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        ball_center_col,
  input  logic [1:0]         ball_direction,
  input  logic               start,
  output logic [SCORE_W-1:0] l_score,
  output logic [SCORE_W-1:0] r_score,
  output logic               ball_enable,
  output logic               serve,
  output logic [1:0]         serve_dir,
  output logic               game_over
);

`ifdef PONG_WIN_LIMIT_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  localparam int                 CNT_W      = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(SERVE_DELAY - 1);
  localparam logic [11:0]        L_MISS_MAX = 12'(L_GOAL_COL + B_WIDTH / 2);
  localparam logic [12:0]        HALF_W     = 13'(B_WIDTH / 2);
  localparam logic [12:0]        R_LINE     = 13'(R_GOAL_COL);
  localparam logic [SCORE_W-1:0] WIN_M1     = SCORE_W'(WIN_SCORE - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             toggle;
  logic             left_cond, right_cond;
  logic             left_miss, right_miss, miss;
  logic             win_go, start_game, enter_wait;
  logic             ball_enable_d, serve_d;
  logic             unused_dir_bit;

  // Only the horizontal bit of the direction matters to the referee.
  assign unused_dir_bit = ball_direction[0];

  // Left test on the centre avoids subtracting; right test is widened to 13 bits.
  assign left_cond  = !ball_direction[1] && (ball_center_col <= L_MISS_MAX);
  assign right_cond =  ball_direction[1] && (({1'b0, ball_center_col} + HALF_W) >= R_LINE);
  assign left_miss  = (state == PLAY) && left_cond;
  assign right_miss = (state == PLAY) && right_cond && !left_cond;
  assign miss       = left_miss || right_miss;

  assign win_go     = WIN_EN && (left_miss ? (r_score == WIN_M1) : (l_score == WIN_M1));
  assign start_game = start && ((state == IDLE) || (state == OVER));
  assign enter_wait = (state_next == WAIT) && (state != WAIT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaulting every always_comb output first keeps synthesis from
  // inferring latches on paths that do not assign it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)       state_next = WAIT;
      WAIT:    if (cnt == '0)   state_next = PLAY;
      PLAY:    if (miss)        state_next = win_go ? OVER : WAIT;
      OVER:    if (start)       state_next = WAIT;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    ball_enable_d = (state_next == PLAY);
    serve_d       = (state == WAIT) && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ball_enable <= 1'b0;
      serve       <= 1'b0;
    end else begin
      ball_enable <= ball_enable_d;
      serve       <= serve_d;
    end
  end

`ifdef PONG_WIN_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) game_over <= 1'b0;
    else     game_over <= (state_next == OVER);
  end
`else
  assign game_over = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enter_wait) begin
      cnt <= CNT_LOAD;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Serve goes toward the player who conceded, alternating up/down each miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle    <= 1'b0;
      serve_dir <= DOWN_RIGHT;
    end else if (miss) begin
      toggle    <= ~toggle;
      serve_dir <= {right_miss, ~toggle};
    end else if (start_game) begin
      serve_dir <= DOWN_RIGHT;
    end
  end

  score_counter u_l_score (
    .clk   (clk),
    .rst   (rst),
    .clear (start && (state == OVER)),
    .inc   (right_miss),
    .count (l_score)
  );

  score_counter u_r_score (
    .clk   (clk),
    .rst   (rst),
    .clear (start && (state == OVER)),
    .inc   (left_miss),
    .count (r_score)
  );

endmodule

// File: tb/tb_pong_referee.sv
// Randomised self-checking bench for pong_referee against a behavioural rally model.
module tb_pong_referee;

  localparam int SD        = 8;
  localparam int WS        = 3;
  localparam int COLS      = 800;
  localparam int HALF_B    = 3;
  localparam int L_GOAL    = 4;
  localparam int R_GOAL    = COLS - 4;
`ifdef PONG_WIN_LIMIT_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ball_center_col;
  logic [1:0]  ball_direction;
  logic        start;
  logic [3:0]  l_score, r_score;
  logic        ball_enable, serve, game_over;
  logic [1:0]  serve_dir;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: phase flags, cycles remaining until the serve, plain int scores.
  bit         m_idle, m_play, m_over, m_serve, m_tog;
  int         m_wait, m_l, m_r;
  logic [1:0] m_dir;

  pong_referee #(
    .DISP_COLS   (COLS),
    .B_WIDTH     (6),
    .L_GOAL_COL  (L_GOAL),
    .R_GOAL_COL  (R_GOAL),
    .SERVE_DELAY (SD),
    .WIN_SCORE   (WS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ball_center_col (ball_center_col),
    .ball_direction  (ball_direction),
    .start           (start),
    .l_score         (l_score),
    .r_score         (r_score),
    .ball_enable     (ball_enable),
    .serve           (serve),
    .serve_dir       (serve_dir),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_step();
    int  col;
    bit  lm, rm;
    int  scored;
    col     = int'(ball_center_col);
    m_serve = 1'b0;
    if (rst) begin
      m_idle = 1; m_play = 0; m_over = 0; m_wait = -1;
      m_l = 0; m_r = 0; m_tog = 0; m_dir = 2'b11;
    end else if ((m_idle || m_over) && start) begin
      if (m_over) begin m_l = 0; m_r = 0; end
      m_idle = 0; m_over = 0; m_wait = SD; m_dir = 2'b11;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_serve = 1; m_play = 1; m_wait = -1;
      end
    end else if (m_play) begin
      // Ball edges are centre -/+ half width; goal lines are inclusive.
      lm = !ball_direction[1] && (col - HALF_B <= L_GOAL);
      rm =  ball_direction[1] && (col + HALF_B >= R_GOAL);
      if (lm || rm) begin
        if (lm) begin m_r = sat15(m_r + 1); scored = m_r; end
        else    begin m_l = sat15(m_l + 1); scored = m_l; end
        m_tog  = !m_tog;
        m_dir  = {!lm, m_tog};
        m_play = 0;
        if (WIN_EN && scored == WS) m_over = 1;
        else                        m_wait = SD;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("l_score",     l_score,     m_l);
    check("r_score",     r_score,     m_r);
    check("ball_enable", ball_enable, m_play);
    check("serve",       serve,       m_serve);
    check("serve_dir",   serve_dir,   m_dir);
    check("game_over",   game_over,   m_over);
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    ball_center_col = 12'd400;
    while (!ball_enable && n < 40) begin
      step();
      n++;
    end
    check("play_timeout", ball_enable, 1);
  endtask

  task automatic right_miss_once();
    wait_play();
    ball_center_col = 12'd793;
    ball_direction  = 2'b10;
    step();
    ball_center_col = 12'd400;
  endtask

  task automatic latency_after_start(input string tag);
    int lat;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step();
      if (serve) lat = i;
    end
    check(tag, lat, SD);
  endtask

  initial begin
    int serves;
    int r;
    rst = 1'b1; start = 1'b0; ball_center_col = 12'd400; ball_direction = 2'b00;
    step(); step();
    check("reset_serve_dir", serve_dir, 2'b11);
    rst = 1'b0;
    step();

    latency_after_start("serve_latency");
    check("first_serve_dir", serve_dir, 2'b11);
    check("enable_with_serve", ball_enable, 1);

    ball_center_col = 12'd7; ball_direction = 2'b00;
    step();
    check("left_miss_score", r_score, 1);
    check("left_miss_enable", ball_enable, 0);
    check("left_miss_dir", serve_dir, 2'b01);

    wait_play();
    ball_center_col = 12'd8; ball_direction = 2'b00;
    repeat (3) step();
    check("col8_no_score", r_score, 1);

    ball_center_col = 12'd793; ball_direction = 2'b10;
    step();
    check("right_miss_score", l_score, 1);
    check("right_miss_dir", serve_dir, 2'b10);

    wait_play();
    ball_center_col = 12'd793; ball_direction = 2'b00;
    repeat (3) step();
    check("dir_filter_right", l_score, 1);
    ball_center_col = 12'd7; ball_direction = 2'b10;
    repeat (3) step();
    check("dir_filter_left", r_score, 1);

    // Miss, then park the ball in the goal zone during WAIT and reset mid-wait.
    ball_center_col = 12'd5; ball_direction = 2'b00;
    step();
    repeat (4) step();
    check("wait_zone_no_score", r_score, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ball_center_col = 12'd400;
    serves = 0;
    repeat (30) begin
      step();
      if (serve) serves++;
    end
    check("no_serve_after_rst", serves, 0);
    check("rst_l_score", l_score, 0);
    check("rst_r_score", r_score, 0);

`ifdef PONG_WIN_LIMIT_EN
    latency_after_start("serve_latency_2");
    repeat (WS) right_miss_once();
    check("win_game_over", game_over, 1);
    check("win_l_score", l_score, WS);
    serves = 0;
    repeat (20) begin
      step();
      if (serve) serves++;
    end
    check("over_no_serve", serves, 0);
    latency_after_start("restart_latency");
    check("restart_l_score", l_score, 0);
    check("restart_r_score", r_score, 0);
`else
    latency_after_start("serve_latency_2");
    repeat (20) right_miss_once();
    check("saturate_l_score", l_score, 15);
    check("no_game_over", game_over, 0);
`endif

    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 15) == 0);
      r = int'($urandom_range(0, 9));
      case (r)
        0:       ball_center_col = 12'($urandom_range(0, 7));
        1:       ball_center_col = 12'($urandom_range(792, 799));
        2:       ball_center_col = ($urandom_range(0, 1) == 0) ? 12'd8 : 12'd792;
        default: ball_center_col = 12'($urandom_range(0, COLS - 1));
      endcase
      ball_direction = 2'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
